// File: rtl/dfe_pkg.sv
// Shared definitions for the frequency-extraction IP.
// Width helper, fill FSM encoding and BRAM byte-address shift.
package dfe_pkg;

   localparam int BRAM_BYTE_SHIFT = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } fill_state_t;

   function automatic integer log2(input integer value);
      integer v;
      integer r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_fill_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping.
// Purely combinational; the grant register lives in the parent.
module rr_arbiter
   import dfe_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]                        req,
   input  logic [((N > 1) ? log2(N) : 1)-1:0] rr_ptr,
   output logic [N-1:0]                        gnt_next
);

   logic found;
   int   j;

   always_comb begin
      gnt_next = '0;
      found    = 1'b0;
      j        = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(rr_ptr) + k) % N;
         if (!found && req[j]) begin
            gnt_next[j] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_fill_arbiter.sv
// Grants the stream-data BRAM port to one processor at a time and
// streams its region into the processor's init-stream port.
module stream_fill_arbiter
   import dfe_pkg::*;
#(
   parameter int LENGTH_ARRAY     = 100,
   parameter int NUM_PROCESSOR    = 3,
   parameter int DATA_INDEX_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PROCESSOR-1:0]        req,
   output logic [NUM_PROCESSOR-1:0]        grant,
   output logic [NUM_PROCESSOR-1:0]        done,
   output logic                            busy,
   output logic [31:0]                     br_memory_addr,
   output logic                            br_memory_clk,
   output logic [31:0]                     br_memory_din,
   input  logic [31:0]                     br_memory_dout,
   output logic                            br_memory_en,
   output logic                            br_memory_rst,
   output logic [3:0]                      br_memory_we,
   output logic                            wr_stream_data,
   output logic [log2(LENGTH_ARRAY)-1:0]   addr_stream_data,
   output logic [DATA_INDEX_WIDTH-1:0]     stream_data
);

   localparam int AW = log2(LENGTH_ARRAY);
   localparam int PW = (NUM_PROCESSOR > 1) ? log2(NUM_PROCESSOR) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(LENGTH_ARRAY - 1);
   localparam logic [PW-1:0] LAST_G   = PW'(NUM_PROCESSOR - 1);

   fill_state_t              state_q,  state_d;
   logic [NUM_PROCESSOR-1:0] grant_q,  grant_d;
   logic [NUM_PROCESSOR-1:0] done_q,   done_d;
   logic [PW-1:0]            gidx_q,   gidx_d;
   logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]            rd_idx_q, rd_idx_d;
   logic [AW-1:0]            waddr_q,  waddr_d;
   logic [31:0]              addr_q,   addr_d;
   logic                     en_q,     en_d;
   logic                     wr_q,     wr_d;

   logic [NUM_PROCESSOR-1:0] gnt_next;
   logic [PW-1:0]            gnt_idx;
   logic [PW-1:0]            next_ptr;
   logic                     owner_req;

   rr_arbiter #(
      .N (NUM_PROCESSOR)
   ) u_rr (
      .req      (req),
      .rr_ptr   (rr_ptr_q),
      .gnt_next (gnt_next)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_PROCESSOR; i++) begin
         if (gnt_next[i]) gnt_idx = PW'(i);
      end
   end

   assign next_ptr  = (gidx_q == LAST_G) ? '0 : gidx_q + 1'b1;
   assign owner_req = |(req & grant_q);

   // The write stage is simply the issue stage delayed by one cycle,
   // which lines it up with the BRAM read latency.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      rr_ptr_d = rr_ptr_q;
      rd_idx_d = rd_idx_q;
      done_d   = '0;
      en_d     = 1'b0;
      addr_d   = '0;
      wr_d     = en_q;
      waddr_d  = en_q ? rd_idx_q : '0;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d  = S_READ;
               grant_d  = gnt_next;
               gidx_d   = gnt_idx;
               rd_idx_d = '0;
               en_d     = 1'b1;
               addr_d   = 32'(gnt_idx) * 32'(LENGTH_ARRAY);
            end
         end
         S_READ, S_DRAIN: begin
            if (!owner_req) begin
               state_d  = S_IDLE;
               grant_d  = '0;
               wr_d     = 1'b0;
               waddr_d  = '0;
               rr_ptr_d = next_ptr;
            end else if (state_q == S_DRAIN) begin
               state_d = S_DONE;
               done_d  = grant_q;
            end else if (rd_idx_q == LAST_IDX) begin
               state_d = S_DRAIN;
            end else begin
               rd_idx_d = rd_idx_q + 1'b1;
               en_d     = 1'b1;
               addr_d   = addr_q + 32'd1;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         done_q   <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         rd_idx_q <= '0;
         waddr_q  <= '0;
         addr_q   <= '0;
         en_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         gidx_q   <= gidx_d;
         rr_ptr_q <= rr_ptr_d;
         rd_idx_q <= rd_idx_d;
         waddr_q  <= waddr_d;
         addr_q   <= addr_d;
         en_q     <= en_d;
         wr_q     <= wr_d;
      end
   end

   assign grant            = grant_q;
   assign done             = done_q;
   assign busy             = (state_q != S_IDLE);
   assign br_memory_clk    = clk;
   assign br_memory_addr   = addr_q << BRAM_BYTE_SHIFT;
   assign br_memory_en     = en_q;
   assign br_memory_din    = '0;
   assign br_memory_rst    = 1'b0;
   assign br_memory_we     = '0;
   assign wr_stream_data   = wr_q;
   assign addr_stream_data = waddr_q;
   assign stream_data      = br_memory_dout[DATA_INDEX_WIDTH-1:0];

endmodule

// File: tb/tb_stream_fill_arbiter.sv
// Scoreboard bench for stream_fill_arbiter with a transaction-level
// round-robin model and a BRAM that returns the word address as data.
module tb_stream_fill_arbiter;

   localparam int L  = 4;
   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 2;
   localparam logic [31:0] SALT = 32'h5A00_0000;

   localparam int EV_GRANT = 0;
   localparam int EV_WR    = 1;
   localparam int EV_DONE  = 2;

   typedef struct {
      int          kind;
      int          g;
      int          idx;
      logic [31:0] data;
      bit          b2b;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  grant;
   logic [N-1:0]  done;
   logic          busy;
   logic [31:0]   br_memory_addr;
   logic          br_memory_clk;
   logic [31:0]   br_memory_din;
   logic [31:0]   br_memory_dout = '0;
   logic          br_memory_en;
   logic          br_memory_rst;
   logic [3:0]    br_memory_we;
   logic          wr_stream_data;
   logic [AW-1:0] addr_stream_data;
   logic [DW-1:0] stream_data;

   stream_fill_arbiter #(
      .LENGTH_ARRAY     (L),
      .NUM_PROCESSOR    (N),
      .DATA_INDEX_WIDTH (DW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req              (req),
      .grant            (grant),
      .done             (done),
      .busy             (busy),
      .br_memory_addr   (br_memory_addr),
      .br_memory_clk    (br_memory_clk),
      .br_memory_din    (br_memory_din),
      .br_memory_dout   (br_memory_dout),
      .br_memory_en     (br_memory_en),
      .br_memory_rst    (br_memory_rst),
      .br_memory_we     (br_memory_we),
      .wr_stream_data   (wr_stream_data),
      .addr_stream_data (addr_stream_data),
      .stream_data      (stream_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (br_memory_en) br_memory_dout <= (br_memory_addr >> 2) ^ SALT;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  total = 0;
   int  bad = 0;
   ev_t expq[$];
   bit  mon_en = 1'b1;
   int  model_p = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic get_ev(input int kind, output ev_t e, output bit ok);
      ok = 1'b0;
      e = '{default: 0};
      total++;
      if (expq.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event act_kind=%0d exp=none t=%0t", kind, $time);
      end else if (expq[0].kind != kind) begin
         bad++;
         $display("FAIL event_order act_kind=%0d exp_kind=%0d t=%0t",
                  kind, expq[0].kind, $time);
      end else begin
         e = expq.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {grant, done, busy, wr_stream_data, br_memory_en,
               addr_stream_data, br_memory_addr}, 0);
   endtask

   // monitor
   logic [N-1:0] prev_g = '0;
   int  cur_g = 0;
   int  issue_n = 0;
   int  gcyc = 0;
   int  ldone_cyc = 0;
   ev_t me;
   bit  mok;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_g = '0;
      end else if (mon_en) begin
         chk("bram_we", br_memory_we, 0);
         chk("bram_din", br_memory_din, 0);
         chk("bram_rst", br_memory_rst, 0);
         chk("busy_vs_grant", busy, |grant);
         if (grant != 0 && prev_g == 0) begin
            get_ev(EV_GRANT, me, mok);
            if (mok) begin
               chk("grant", grant, 32'd1 << me.g);
               if (me.b2b) chk("burst_gap", cyc, ldone_cyc + 2);
               cur_g = me.g;
            end
            issue_n = 0;
            gcyc = cyc;
         end
         if (grant == 0) begin
            chk("idle_strobes", {br_memory_en, wr_stream_data, done}, 0);
         end
         if (br_memory_en) begin
            chk("read_addr", br_memory_addr, (cur_g * L + issue_n) << 2);
            chk("read_count", issue_n < L, 1);
            issue_n++;
         end
         if (wr_stream_data) begin
            get_ev(EV_WR, me, mok);
            if (mok) begin
               chk("wr_idx", addr_stream_data, me.idx);
               chk("wr_data", stream_data, me.data);
               chk("wr_owner", grant, 32'd1 << me.g);
            end
         end
         if (done != 0) begin
            get_ev(EV_DONE, me, mok);
            if (mok) begin
               chk("done", done, 32'd1 << me.g);
               chk("done_latency", cyc - gcyc, L + 1);
            end
            ldone_cyc = cyc;
         end
         prev_g = grant;
      end
   end

   // Each requester wants cnt[i] bursts; ab>0 aborts the phase's first
   // burst by dropping its request in cycle ab of that burst.
   task automatic run_phase(input int c0, input int c1, input int c2,
                            input int ab);
      int cnt[N];
      int mc[N];
      int p, g, nw, k, ag, ab_st, budget;
      bit first, pd, abort_now;
      cnt[0] = c0;
      cnt[1] = c1;
      cnt[2] = c2;
      mc = cnt;
      p = model_p;
      first = 1'b1;
      pd = 1'b0;
      while (mc[0] + mc[1] + mc[2] > 0) begin
         g = -1;
         for (int s = 0; s < N; s++) begin
            if (g < 0 && mc[(p + s) % N] > 0) g = (p + s) % N;
         end
         expq.push_back('{EV_GRANT, g, 0, 32'd0, pd});
         nw = (first && ab > 0) ? ab - 1 : L;
         for (int i = 0; i < nw; i++) begin
            expq.push_back('{EV_WR, g, i, 32'(g * L + i) ^ SALT, 1'b0});
         end
         if (first && ab > 0) begin
            pd = 1'b0;
         end else begin
            expq.push_back('{EV_DONE, g, 0, 32'd0, 1'b0});
            pd = 1'b1;
         end
         mc[g]--;
         p = (g + 1) % N;
         first = 1'b0;
      end
      model_p = p;

      @(negedge clk);
      for (int i = 0; i < N; i++) req[i] = (cnt[i] > 0);
      ab_st = (ab > 0) ? 0 : 2;
      k = 0;
      ag = 0;
      budget = 0;
      while (!(req == 0 && !busy) && budget < 400) begin
         @(negedge clk);
         budget++;
         abort_now = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (done[i] && cnt[i] > 0) cnt[i]--;
         end
         if (ab_st == 0 && grant != 0) begin
            ab_st = 1;
            k = 1;
            for (int i = 0; i < N; i++) if (grant[i]) ag = i;
         end else if (ab_st == 1) begin
            k++;
         end
         if (ab_st == 1 && k == ab) begin
            cnt[ag]--;
            abort_now = 1'b1;
            ab_st = 2;
         end
         for (int i = 0; i < N; i++) req[i] = (cnt[i] > 0);
         if (abort_now) req[ag] = 1'b0;
      end
      chk("phase_timeout", budget >= 400, 0);
      req = '0;
      repeat (2) @(negedge clk);
      chk("queue_empty", expq.size(), 0);
      expq.delete();
   endtask

   initial begin
      int w;
      int c[N];
      int ab;
      #1 rst_n = 1'b0;
      #1 chk_all_zero("reset_outputs");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_all_zero("idle_no_req");
      end

      run_phase(0, 1, 0, 0);
      run_phase(1, 1, 0, 0);

      // async reset in the middle of a read burst
      mon_en = 1'b0;
      @(negedge clk);
      req = 3'b010;
      w = 0;
      while (grant == 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("reset_burst_start", w < 20, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset_mid_burst");
      req = '0;
      model_p = 0;
      expq.delete();
      repeat (2) @(negedge clk);
      chk_all_zero("held_reset");
      rst_n = 1'b1;
      mon_en = 1'b1;

      run_phase(2, 1, 1, 0);
      run_phase(0, 0, 1, 0);
      run_phase(2, 0, 1, 2);

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N; i++) c[i] = $urandom_range(0, 2);
         if (c[0] + c[1] + c[2] == 0) c[$urandom_range(0, N - 1)] = 1;
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, L + 1) : 0;
         run_phase(c[0], c[1], c[2], ab);
      end

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("final_idle", {grant, done, busy, wr_stream_data, br_memory_en}, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stream_fill_arbiter.md
# stream_fill_arbiter

Shares the single stream-data block RAM port between `NUM_PROCESSOR` frequency-extraction processors. Each processor raises a fill request; the block grants one at a time in round-robin order, reads that processor's `LENGTH_ARRAY`-word region from BRAM, and streams it into the processor's init-stream port. It absorbs the 1-cycle BRAM read latency and replaces the per-processor free-running fill counters.

## Interface
- `LENGTH_ARRAY`, 100: words per processor region and per burst.
- `NUM_PROCESSOR`, 3: number of requesters.
- `DATA_INDEX_WIDTH`, 32: stream word width; must be ≤ 32.
- `clk`  in  1  sole clock; also forwarded on `br_memory_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_PROCESSOR  level fill request per processor; held until `done` or abort.
- `grant`  out  NUM_PROCESSOR  one-hot (or zero) current owner.
- `done`  out  NUM_PROCESSOR  one-cycle pulse to the owner at burst completion.
- `busy`  out  1  high in every state except IDLE.
- `br_memory_addr`  out  32  byte address = word address << 2.
- `br_memory_clk`  out  1  = `clk`.
- `br_memory_din`  out  32  constant 0.
- `br_memory_dout`  in  32  read data, valid 1 cycle after address.
- `br_memory_en`  out  1  high only while issuing reads.
- `br_memory_rst`  out  1  constant 0.
- `br_memory_we`  out  4  constant 0.
- `wr_stream_data`  out  1  write strobe, broadcast; processors qualify with `grant`.
- `addr_stream_data`  out  log2(LENGTH_ARRAY)  local word index 0..LENGTH_ARRAY-1.
- `stream_data`  out  DATA_INDEX_WIDTH  = `br_memory_dout[DATA_INDEX_WIDTH-1:0]`.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: if any `req` is set, pick the first set bit starting at `rr_ptr` (wrapping), register `grant`, clear `rd_idx`, go to READ. Otherwise stay.
- READ: `br_memory_en`=1; word address = g*LENGTH_ARRAY + `rd_idx` (32-bit, g = granted index); `rd_idx`++ each cycle; after issuing index LENGTH_ARRAY-1 go to DRAIN.
- Write path: registered copy of issue (valid, index) one cycle later drives `wr_stream_data`/`addr_stream_data`; `stream_data` comes combinationally from `br_memory_dout`.
- DRAIN: no issue; last write occurs here; go to DONE.
- DONE: `done[g]`=1 for one cycle; `rr_ptr` ← (g+1) mod NUM_PROCESSOR; clear `grant`; go to IDLE.
- Abort: if `req[g]` drops in READ or DRAIN, go to IDLE next cycle. `grant` is cleared, `br_memory_en` and `wr_stream_data` are 0 from that cycle, no `done`, and `rr_ptr` still advances past g.
- New or other requests arriving mid-burst wait; arbitration happens only in IDLE.
- A `req` still high after its `done` is treated as a new request and re-arbitrated.

## Timing
- Reset (async, immediate): state IDLE; `grant`, `done`, `busy`, `wr_stream_data`, `br_memory_en` = 0; `addr_stream_data` = 0; `br_memory_addr` = 0; `rr_ptr` = 0.
- `req` sampled high at edge t: `grant`/`busy` high from t+1, reads issued at cycles t+1..t+L, writes at t+2..t+L+1, `done` at t+L+2, IDLE at t+L+3.
- Burst occupancy: L+3 cycles. Back-to-back bursts have a 1-cycle IDLE gap.
- `addr_stream_data` equals the index issued one cycle earlier. Indices are contiguous and never wrap within a burst.
- Reset asserted mid-burst: outputs drop asynchronously, and no partial `done` is produced.

## Structure
- Shared package `dfe_pkg`: the `log2` function (same definition as used across the IP), the state encoding constant, and the BRAM byte-shift constant (2).
- Natural sub-module: `rr_arbiter` (parameter N). Inputs: `req`, `rr_ptr`. Output: one-hot `gnt_next`. Purely combinational; the grant register lives in the parent.
- Target is 150–250 lines of RTL total.

## Test plan
- Single request, L=4, N=3, `req`=3'b010: `grant`=010. `br_memory_addr` = 0x10, 0x14, 0x18, 0x1C. Writes at idx 0..3 with data from BRAM words 4..7. `done[1]` pulses 6 cycles after `req` is sampled.
- All `req`=3'b111 held, `rr_ptr`=0: grants are 001, 010, 100, 001 in order. Each burst is L+3 cycles, with a 1-cycle IDLE gap between bursts.
- Abort: `req[0]` drops after 2 issues. Next cycle: `grant`=0, no further writes, no `done`. A pending `req[2]` is granted before `req[0]`.
- Async reset during READ (mid-cycle): all outputs 0 immediately. After release with `req`=001, the burst restarts at idx 0 with `rr_ptr`=0.
- Latency check with BRAM model returning word address as data: every write has `stream_data` = g*L + `addr_stream_data`. Exactly L writes per burst, and `we`=0 throughout.
- Wrap: `rr_ptr`=2 and `req`=3'b011 → grant 001 first, then 010. An idle `req`=0 leaves all outputs at their reset values.
